// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite slave SRAM with programmable wait states,
// byte-lane writes, a read-only low region and ERROR responses.
module ahb3lite_sram_ws #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0,
  parameter int RO_BYTES    = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [HADDR_SIZE-1:0] HADDR,
  input  logic [HDATA_SIZE-1:0] HWDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [HDATA_SIZE-1:0] HRDATA,
  output logic [7:0]            ERR_CNT
);
  localparam int BYTES = HDATA_SIZE / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int AW    = $clog2(MEM_DEPTH);
  localparam logic [HADDR_SIZE:0] MEM_LIM =
    (HADDR_SIZE+1)'(MEM_DEPTH * BYTES);
  localparam logic [HADDR_SIZE:0] RO_LIM =
    (HADDR_SIZE+1)'(RO_BYTES);
  localparam logic [2:0] SZ_MAX = 3'(LB);
  localparam logic [3:0] WS     = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2
  } state_t;

  state_t                state;
  logic [AW-1:0]         word_q;
  logic [BYTES-1:0]      be_q;
  logic                  write_q;
  logic [3:0]            cnt;
  logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

  logic                  accept;
  logic                  illegal;
  logic                  bad_align;
  logic                  commit;
  logic [AW-1:0]         word;
  logic [BYTES-1:0]      be;
  logic [HDATA_SIZE-1:0] rd_new;
  int                    lane;
  int                    span;
  logic                  unused;

  assign unused  = ^{HTRANS[0], HBURST, HPROT};
  assign accept  = HSEL & HREADY & HTRANS[1];
  assign word    = HADDR[LB +: AW];
  assign commit  = (state == S_DONE) & write_q & ~HRESET;
  assign illegal = ({1'b0, HADDR} >= MEM_LIM)
                 | (HSIZE > SZ_MAX)
                 | bad_align
                 | (HWRITE & ({1'b0, HADDR} < RO_LIM));

  always_comb begin
    unique case (HSIZE)
      3'd0:    bad_align = 1'b0;
      3'd1:    bad_align = HADDR[0];
      3'd2:    bad_align = |HADDR[1:0];
      3'd3:    bad_align = |HADDR[2:0];
      default: bad_align = 1'b1;
    endcase
  end

  always_comb begin
    be   = '0;
    lane = int'(HADDR[LB-1:0]);
    span = 1 << HSIZE;
    for (int i = 0; i < BYTES; i++)
      be[i] = (i >= lane) && (i < lane + span);
  end

  // a write committing this edge is forwarded to a read accepted now
  always_comb begin
    rd_new = mem[word];
    if (commit && (word == word_q))
      for (int i = 0; i < BYTES; i++)
        if (be_q[i])
          rd_new[8*i +: 8] = HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (commit)
      for (int i = 0; i < BYTES; i++)
        if (be_q[i])
          mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      ERR_CNT   <= '0;
      cnt       <= '0;
      word_q    <= '0;
      be_q      <= '0;
      write_q   <= 1'b0;
    end else begin
      unique case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state     <= S_DONE;
            HREADYOUT <= 1'b1;
            HRDATA    <= mem[word_q];
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
          if (ERR_CNT != 8'hFF)
            ERR_CNT <= ERR_CNT + 8'd1;
        end
        default: begin
          HRDATA <= '0;
          if (accept) begin
            word_q  <= word;
            be_q    <= be;
            write_q <= HWRITE;
            if (illegal) begin
              state     <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              write_q   <= 1'b0;
            end else if (WAIT_STATES == 0) begin
              state     <= S_DONE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              HRDATA    <= rd_new;
            end else begin
              state     <= S_WAIT;
              cnt       <= WS;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
            end
          end else begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            write_q   <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Scoreboard bench for ahb3lite_sram_ws: a zero-wait and a
// two-wait instance share one master; a monitor checks responses.
module tb_ahb3lite_sram_ws;
  logic        clk;
  logic        rst;
  logic        sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        write;
  logic [2:0]  size;
  logic [2:0]  burst;
  logic [3:0]  prot;
  logic [1:0]  trans;
  logic        tgt;

  logic        ro0, ro1, rs0, rs1;
  logic [31:0] rd0, rd1;
  logic [7:0]  ec0, ec1;
  logic        hready, resp;
  logic [31:0] rdata;
  logic [7:0]  errcnt;

  assign hready = tgt ? ro1 : ro0;
  assign resp   = tgt ? rs1 : rs0;
  assign rdata  = tgt ? rd1 : rd0;
  assign errcnt = tgt ? ec1 : ec0;

  ahb3lite_sram_ws #(.WAIT_STATES(0), .RO_BYTES(16)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel & ~tgt),
    .HADDR(addr), .HWDATA(wdata), .HWRITE(write),
    .HSIZE(size), .HBURST(burst), .HPROT(prot),
    .HTRANS(trans), .HREADY(hready), .HREADYOUT(ro0),
    .HRESP(rs0), .HRDATA(rd0), .ERR_CNT(ec0)
  );

  ahb3lite_sram_ws #(.WAIT_STATES(2), .RO_BYTES(16)) u1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel & tgt),
    .HADDR(addr), .HWDATA(wdata), .HWRITE(write),
    .HSIZE(size), .HBURST(burst), .HPROT(prot),
    .HTRANS(trans), .HREADY(hready), .HREADYOUT(ro1),
    .HRESP(rs1), .HRDATA(rd1), .ERR_CNT(ec1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        err;
    logic        wr;
    logic [31:0] rd;
    int          ws;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic inflight = 1'b0;
  int   wcnt     = 0;
  int   n_cmp    = 0;
  int   n_bad    = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0]  tr,
                       input logic [31:0] a,
                       input logic        w,
                       input logic [2:0]  sz,
                       input logic [31:0] wd,
                       input logic        e,
                       input logic [31:0] rd);
    int n;
    n = 0;
    sel = 1'b1; trans = tr; addr = a;
    write = w; size = sz;
    while (!hready && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: addr %h", a);
    end
    if (tr[1])
      q.push_back('{e, w, rd, e ? 1 : (tgt ? 2 : 0)});
    step();
    wdata = wd;
  endtask

  task automatic idle();
    int n;
    n = 0;
    sel = 1'b0;
    trans = 2'd0;
    while (!hready && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: hready %b want 1", hready);
    end
    step();
    step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 1'b0;
        wcnt = 0;
        q.delete();
      end else begin
        if (inflight) begin
          if (!hready) begin
            check("wait_resp", 32'(resp), 32'(cur.err));
            check("wait_rdata", rdata, 32'd0);
            wcnt++;
          end else begin
            check("resp", 32'(resp), 32'(cur.err));
            check("waits", 32'(wcnt), 32'(cur.ws));
            if (!cur.wr && !cur.err)
              check("rdata", rdata, cur.rd);
            inflight = 1'b0;
          end
        end
        if (sel && hready && trans[1]) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: accept %h none expected",
                     addr);
          end else begin
            cur = q.pop_front();
            inflight = 1'b1;
            wcnt = 0;
          end
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    check({tag, "_hreadyout"}, 32'(hready), 32'd1);
    check({tag, "_hresp"}, 32'(resp), 32'd0);
    check({tag, "_hrdata"}, rdata, 32'd0);
    check({tag, "_err_cnt"}, 32'(errcnt), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0; trans = 2'd0; addr = '0;
    wdata = '0; write = 1'b0; size = 3'd2;
    burst = 3'd0; prot = 4'd0; tgt = 1'b0;
    repeat (3) step();
    chk_reset("rst0");
    tgt = 1'b1;
    chk_reset("rst1");
    tgt = 1'b0;
    rst = 1'b0;
    step();

    // zero wait states, read right after write
    issue(2'd2, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(2'd2, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
    idle();

    // byte and halfword lanes
    issue(2'd2, 32'h20, 1'b1, 3'd2, 32'h0, 1'b0, 32'h0);
    issue(2'd2, 32'h21, 1'b1, 3'd0, 32'h0000AA00, 1'b0, 32'h0);
    issue(2'd2, 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0000AA00);
    issue(2'd2, 32'h22, 1'b1, 3'd1, 32'h12340000, 1'b0, 32'h0);
    issue(2'd2, 32'h20, 1'b0, 3'd2, 32'h0, 1'b0, 32'h1234AA00);
    issue(2'd2, 32'h3FC, 1'b1, 3'd2, 32'hA5A5A5A5, 1'b0, 32'h0);
    issue(2'd2, 32'h3FC, 1'b0, 3'd2, 32'h0, 1'b0, 32'hA5A5A5A5);
    idle();

    // illegal transfers
    issue(2'd2, 32'h400, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0);
    issue(2'd2, 32'h2, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0);
    issue(2'd2, 32'h0, 1'b1, 3'd2, 32'h11, 1'b1, 32'h0);
    issue(2'd2, 32'hC, 1'b1, 3'd2, 32'h22, 1'b1, 32'h0);
    issue(2'd2, 32'h12, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b1, 32'h0);
    issue(2'd2, 32'h8, 1'b0, 3'd3, 32'h0, 1'b1, 32'h0);
    issue(2'd2, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hDEADBEEF);
    idle();
    check("err_cnt", 32'(errcnt), 32'd6);

    // INCR4 burst, pipelined read, BUSY mid-burst
    issue(2'd2, 32'h58, 1'b1, 3'd2, 32'h11111111, 1'b0, 32'h0);
    issue(2'd2, 32'h40, 1'b1, 3'd2, 32'd1, 1'b0, 32'h0);
    issue(2'd3, 32'h44, 1'b1, 3'd2, 32'd2, 1'b0, 32'h0);
    issue(2'd3, 32'h48, 1'b1, 3'd2, 32'd3, 1'b0, 32'h0);
    issue(2'd3, 32'h4C, 1'b1, 3'd2, 32'd4, 1'b0, 32'h0);
    issue(2'd2, 32'h4C, 1'b0, 3'd2, 32'h0, 1'b0, 32'd4);
    issue(2'd2, 32'h50, 1'b1, 3'd2, 32'd5, 1'b0, 32'h0);
    issue(2'd1, 32'h58, 1'b1, 3'd2, 32'hFFFFFFFF, 1'b0, 32'h0);
    issue(2'd3, 32'h54, 1'b1, 3'd2, 32'd6, 1'b0, 32'h0);
    issue(2'd2, 32'h50, 1'b0, 3'd2, 32'h0, 1'b0, 32'd5);
    issue(2'd2, 32'h54, 1'b0, 3'd2, 32'h0, 1'b0, 32'd6);
    issue(2'd2, 32'h58, 1'b0, 3'd2, 32'h0, 1'b0, 32'h11111111);
    issue(2'd2, 32'h40, 1'b0, 3'd2, 32'h0, 1'b0, 32'd1);
    idle();

    // two wait states
    tgt = 1'b1;
    step();
    issue(2'd2, 32'h10, 1'b1, 3'd2, 32'hCAFE0001, 1'b0, 32'h0);
    issue(2'd2, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hCAFE0001);
    idle();

    // reset while a write sits in its wait states
    issue(2'd2, 32'h10, 1'b1, 3'd2, 32'hBAD0BAD0, 1'b0, 32'h0);
    sel = 1'b0;
    trans = 2'd0;
    rst = 1'b1;
    repeat (3) step();
    chk_reset("midrst");
    rst = 1'b0;
    step();
    issue(2'd2, 32'h10, 1'b0, 3'd2, 32'h0, 1'b0, 32'hCAFE0001);
    idle();
    tgt = 1'b0;
    step();
    check("err_cnt_after_rst", 32'(errcnt), 32'd0);

    n = 0;
    while ((q.size() != 0 || inflight) && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
